// File: rtl/pe_pkg.sv
// Shared PE definitions: default spad geometry and the spad control state
// encoding used by the weight, ifmap and psum scratchpads.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    SPAD_IDLE  = 2'd0,
    SPAD_FILL  = 2'd1,
    SPAD_READY = 2'd2
  } spad_state_t;

endpackage

// File: rtl/spad_mem.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Kept free of reset so a hard memory macro can replace it directly.
module spad_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_spad_seq.sv
// Weight scratchpad: burst fill over valid/ready, then registered random or
// wrapping sequential reads over the loaded filter length.
module weight_spad_seq
  import pe_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_fill,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              fill_last,
  output logic              fill_ready,
  input  logic              rd_en,
  input  logic              rd_seq,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_wrap,
  output logic [ADDR_W:0]   count,
  output logic              loaded
);

  spad_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              rd_valid_reg, rd_wrap_reg, zero_reg;
  logic [DATA_W-1:0] mem_q;

  logic              beat, rd_accept, last_entry, count_full, oob;
  logic [ADDR_W-1:0] mem_raddr;

  assign beat       = (state_reg == SPAD_FILL) && fill_valid && !start_fill;
  assign rd_accept  = (state_reg == SPAD_READY) && rd_en && !start_fill;
  assign last_entry = ({1'b0, rd_ptr_reg} == (count_reg - (ADDR_W+1)'(1)));
  assign count_full = ((count_reg + (ADDR_W+1)'(1)) == (ADDR_W+1)'(DEPTH));
  assign oob        = ({1'b0, rd_addr} >= count_reg);
  assign mem_raddr  = rd_seq ? rd_ptr_reg : rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SPAD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fill_ready = 1'b0;
    loaded     = 1'b0;
    case (state_reg)
      SPAD_IDLE: begin
        if (start_fill) state_next = SPAD_FILL;
      end
      SPAD_FILL: begin
        fill_ready = 1'b1;
        if (start_fill) begin
          state_next = SPAD_FILL;
        end else if (beat && (fill_last || count_full)) begin
          state_next = SPAD_READY;
        end
      end
      SPAD_READY: begin
        loaded = 1'b1;
        if (start_fill) state_next = SPAD_FILL;
      end
      default: state_next = SPAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (start_fill) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (beat) begin
      wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      count_reg  <= count_reg + (ADDR_W+1)'(1);
    end else if (rd_accept && rd_seq) begin
      rd_ptr_reg <= last_entry ? '0 : rd_ptr_reg + ADDR_W'(1);
    end
  end

  // zero_reg masks the raw memory output: it covers out-of-range random
  // reads and the unwritten array after reset, and only changes on a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_wrap_reg  <= 1'b0;
      zero_reg     <= 1'b1;
    end else begin
      rd_valid_reg <= rd_accept;
      rd_wrap_reg  <= rd_accept && rd_seq && last_entry;
      if (rd_accept) begin
        zero_reg <= !rd_seq && oob;
      end
    end
  end

  spad_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (beat),
    .waddr(wr_ptr_reg),
    .wdata(fill_data),
    .re   (rd_accept),
    .raddr(mem_raddr),
    .rdata(mem_q)
  );

  assign rd_valid = rd_valid_reg;
  assign rd_wrap  = rd_wrap_reg;
  assign rd_data  = zero_reg ? '0 : mem_q;
  assign count    = count_reg;

endmodule

// File: tb/tb_weight_spad_seq.sv
// Bench for weight_spad_seq: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a behavioural model.
module tb_weight_spad_seq;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start_fill = 1'b0;
  logic              fill_valid = 1'b0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              fill_last = 1'b0;
  logic              fill_ready;
  logic              rd_en = 1'b0;
  logic              rd_seq = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_wrap;
  logic [ADDR_W:0]   count;
  logic              loaded;

  int n_checks = 0;
  int n_fail   = 0;

  weight_spad_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_last(fill_last), .fill_ready(fill_ready),
    .rd_en(rd_en), .rd_seq(rd_seq), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_wrap(rd_wrap), .count(count), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: 0 = idle, 1 = loading, 2 = loaded.
  int m_mode = 0, m_cnt = 0, m_ptr = 0, m_valid = 0, m_wrap = 0, m_data = 0;
  int m_mem [DEPTH];

  logic s_rst, s_sf, s_fv, s_fl, s_re, s_rs;
  logic [DATA_W-1:0] s_fd;
  logic [ADDR_W-1:0] s_ra;

  task automatic model_step();
    m_valid = 0;
    m_wrap  = 0;
    if (!s_rst) begin
      m_mode = 0; m_cnt = 0; m_ptr = 0; m_data = 0;
    end else if (s_sf) begin
      m_mode = 1; m_cnt = 0; m_ptr = 0;
    end else if (m_mode == 1 && s_fv) begin
      m_mem[m_cnt] = int'(s_fd);
      m_cnt++;
      if (s_fl || m_cnt == DEPTH) m_mode = 2;
    end else if (m_mode == 2 && s_re) begin
      m_valid = 1;
      if (s_rs) begin
        m_data = m_mem[m_ptr];
        m_wrap = (m_ptr == m_cnt - 1) ? 1 : 0;
        m_ptr  = (m_ptr + 1) % m_cnt;
      end else begin
        m_data = (int'(s_ra) < m_cnt) ? m_mem[int'(s_ra)] : 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_sf = start_fill; s_fv = fill_valid; s_fd = fill_data;
      s_fl = fill_last; s_re = rd_en; s_rs = rd_seq; s_ra = rd_addr;
      #1;
      model_step();
      check("cyc_rd_valid", 32'(rd_valid), 32'(m_valid));
      check("cyc_rd_wrap", 32'(rd_wrap), 32'(m_wrap));
      check("cyc_rd_data", 32'(rd_data), 32'(m_data));
      check("cyc_count", 32'(count), 32'(m_cnt));
      check("cyc_fill_ready", 32'(fill_ready), 32'(m_mode == 1));
      check("cyc_loaded", 32'(loaded), 32'(m_mode == 2));
    end
  end

  task automatic drive(input logic sf, input logic fv, input logic [7:0] fd, input logic fl,
                       input logic re, input logic rs, input logic [ADDR_W-1:0] ra);
    @(negedge clk);
    start_fill = sf; fill_valid = fv; fill_data = fd; fill_last = fl;
    rd_en = re; rd_seq = rs; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic read_check(input string name, input logic rs, input logic [ADDR_W-1:0] ra,
                            input logic [7:0] exp_d, input logic exp_w);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, rs, ra);
    @(posedge clk);
    #2;
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check({name, "_data"}, 32'(rd_data), 32'(exp_d));
    check({name, "_wrap"}, 32'(rd_wrap), 32'(exp_w));
  endtask

  logic [7:0] exp_seq [7];

  initial begin
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h11, 8'h12};
    #1 rst_n = 1'b0;
    repeat (2) idle();
    check("rst_count", 32'(count), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_fill_ready", 32'(fill_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Five-beat load.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(8'h11 + i), i == 4, 1'b0, 1'b0, '0);
    idle();
    check("load5_count", 32'(count), 32'd5);
    check("load5_loaded", 32'(loaded), 32'd1);
    check("load5_fill_ready", 32'(fill_ready), 32'd0);

    for (int i = 0; i < 7; i++) read_check("seq", 1'b1, '0, exp_seq[i], i == 4);
    read_check("rand3", 1'b0, 6'd3, 8'h14, 1'b0);
    read_check("rand9_oob", 1'b0, 6'd9, 8'h00, 1'b0);
    read_check("seq_after_rand", 1'b1, '0, 8'h13, 1'b0);
    idle();

    // Full load: 70 beats offered, 64 accepted.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 70; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, '0);
    idle();
    check("full_count", 32'(count), 32'd64);
    check("full_fill_ready", 32'(fill_ready), 32'd0);
    read_check("full_rd63", 1'b0, 6'd63, 8'd63, 1'b0);
    idle();

    // Gapped fill, restart mid-load, then short reload.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) drive(1'b0, (i % 2) == 0, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, '0);
    idle();
    check("reload_count", 32'(count), 32'd2);
    read_check("reload_seq0", 1'b1, '0, 8'hA0, 1'b0);
    read_check("reload_seq1", 1'b1, '0, 8'hA1, 1'b1);
    read_check("reload_seq2", 1'b1, '0, 8'hA0, 1'b0);

    // start_fill collides with a read, then async reset mid-fill.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, '0);
    @(posedge clk);
    #2;
    check("collide_rd_valid", 32'(rd_valid), 32'd0);
    check("collide_fill_ready", 32'(fill_ready), 32'd1);
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_fill_ready", 32'(fill_ready), 32'd0);
    check("arst_loaded", 32'(loaded), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) idle();
    @(negedge clk) rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ADDR_W'($urandom));
    end
    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
